// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants for the instruction fetch unit.
// Holds the boolean constants, the default datapath width and the fetch
// FSM state encoding used by fetch_queue_unit and fetch_queue.
package fetch_queue_unit_pkg;

  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
  localparam int   DATA_WIDTH = 32;

  // IDLE: nothing in flight; WAIT: response will be kept;
  // DROP: response will be discarded (a redirect overtook it).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer holding {instr, pc} pairs.
// Ports:
//   clk, rst          clock, asynchronous active-high reset of pointers/count
//   rdy               global enable; low freezes pointers, count and storage
//   push, push_instr, push_pc   write one entry at the tail
//   pop               retire the head entry
//   flush             empty the buffer; overrides same-cycle push and pop
//   full, empty       occupancy flags
//   head_instr, head_pc         head entry, combinational
module fetch_queue
  import fetch_queue_unit_pkg::*;
#(
  parameter int XLEN   = DATA_WIDTH,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            push,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [XLEN-1:0] head_instr,
  output logic [XLEN-1:0] head_pc
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [XLEN-1:0]  instr_mem [QDEPTH];
  logic [XLEN-1:0]  pc_mem    [QDEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(QDEPTH));
  assign empty   = (count_q == '0);
  assign do_push = rdy && push && !flush && !full;
  assign do_pop  = rdy && pop && !flush && !empty;

  assign head_instr = instr_mem[head_q];
  assign head_pc    = pc_mem[head_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) tail_q <= tail_q + PTR_W'(1);
        if (do_pop)  head_q <= head_q + PTR_W'(1);
        // Push and pop together leave the occupancy unchanged.
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + (PTR_W+1)'(1);
          2'b01:   count_q <= count_q - (PTR_W+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage carries no reset; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[tail_q] <= push_instr;
      pc_mem[tail_q]    <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: issues one memory request at a time, queues the
// returned instructions with their addresses and presents the head to the
// decoder. A redirect flushes the queue and restarts fetching at a new pc.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rdy                           global enable; low freezes everything
//   out_mem_ce, out_mem_pc        one-cycle fetch request and its address
//   in_mem_ce, in_mem_instr       memory response
//   out_valid, out_instr, out_pc  queue head to the decoder
//   in_issue_stall                downstream cannot accept; head is held
//   in_redirect_ce, in_redirect_pc  branch/jump redirect
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              XLEN     = DATA_WIDTH,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic            out_mem_ce,
  output logic [XLEN-1:0] out_mem_pc,
  input  logic            in_mem_ce,
  input  logic [XLEN-1:0] in_mem_instr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            in_issue_stall,
  input  logic            in_redirect_ce,
  input  logic [XLEN-1:0] in_redirect_pc
);

  fq_state_e       state_q;
  fq_state_e       state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic            ce_q;
  logic            ce_d;
  logic [XLEN-1:0] mem_pc_q;
  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic            q_empty;

  fetch_queue #(
    .XLEN   (XLEN),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .push       (q_push),
    .push_instr (in_mem_instr),
    .push_pc    (fetch_pc_q),
    .pop        (q_pop),
    .flush      (in_redirect_ce),
    .full       (q_full),
    .empty      (q_empty),
    .head_instr (out_instr),
    .head_pc    (out_pc)
  );

  assign out_valid  = !q_empty;
  assign q_pop      = out_valid && !in_issue_stall;
  // The request register is frozen while rdy is low, so a pending pulse
  // reappears on the first enabled cycle instead of being lost.
  assign out_mem_ce = ce_q && rdy;
  assign out_mem_pc = mem_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ce_d       = FALSE;
    q_push     = FALSE;
    if (in_redirect_ce) fetch_pc_d = in_redirect_pc;
    case (state_q)
      ST_IDLE: begin
        // Only issue when the response is guaranteed a slot; a same-cycle
        // pop is not credited, so a full queue waits one extra cycle.
        if (!in_redirect_ce && !q_full) begin
          state_d = ST_WAIT;
          ce_d    = TRUE;
        end
      end
      ST_WAIT: begin
        if (in_mem_ce) begin
          state_d = ST_IDLE;
          if (!in_redirect_ce) begin
            q_push     = TRUE;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
        end else if (in_redirect_ce) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (in_mem_ce) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      ce_q       <= FALSE;
      mem_pc_q   <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ce_q       <= ce_d;
      if (ce_d) mem_pc_q <= fetch_pc_q;
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter XLEN, default 32, instruction and address width in bits.
REQ-002 Parameter QDEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rdy  input  1  global enable; low freezes all state.
REQ-007 out_mem_ce  output  1  one-cycle fetch request pulse to memory control.
REQ-008 out_mem_pc  output  XLEN  fetch address; valid while out_mem_ce is high.
REQ-009 in_mem_ce  input  1  one-cycle response valid.
REQ-010 in_mem_instr  input  XLEN  fetched instruction; valid with in_mem_ce.
REQ-011 out_valid  output  1  queue head valid, to decoder.
REQ-012 out_instr  output  XLEN  head instruction.
REQ-013 out_pc  output  XLEN  head instruction address.
REQ-014 in_issue_stall  input  1  RS/LSB/ROB cannot accept; head held.
REQ-015 in_redirect_ce  input  1  branch/jump redirect pulse.
REQ-016 in_redirect_pc  input  XLEN  redirect target.

Function
REQ-017 At most one memory request outstanding at any time.
REQ-018 FSM states: IDLE (no request in flight), WAIT (request in flight, response kept), DROP (request in flight, response discarded).
REQ-019 IDLE->WAIT: when rdy is high, no redirect is present, and count+1 <= QDEPTH. Pulse out_mem_ce for one cycle with out_mem_pc = fetch_pc.
REQ-020 WAIT, in_mem_ce high, no redirect: push {in_mem_instr, fetch_pc} at the tail, fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN), ->IDLE.
REQ-021 DROP, in_mem_ce high: discard the response, fetch_pc unchanged, ->IDLE.
REQ-022 in_redirect_ce in any state clears the queue (count=0) and sets fetch_pc <= in_redirect_pc; WAIT->DROP, DROP stays DROP, IDLE stays IDLE with no request that cycle.
REQ-023 Redirect in the same cycle as in_mem_ce: the response is dropped, fetch_pc <= in_redirect_pc, ->IDLE.
REQ-024 Redirect overrides same-cycle push and pop; the popped head is not counted as issued.
REQ-025 out_valid = (count != 0). out_instr and out_pc are driven combinationally from the head entry; their values are don't-care when out_valid is low.
REQ-026 Pop occurs when out_valid is high and in_issue_stall is low; head advances at posedge.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-028 Full (count=QDEPTH): no new request is issued; pop frees a slot and a request is issued no earlier than the next cycle.
REQ-029 Pointers are log2(QDEPTH) bits and wrap naturally; count is log2(QDEPTH)+1 bits.
REQ-030 rdy low: no state, pointer, or count change; out_mem_ce low; in_mem_ce and in_redirect_ce ignored.
REQ-031 Minimum fetch latency: request in cycle N, response in cycle N+k, instruction visible on out_valid in cycle N+k+1.

Reset
REQ-032 On rst high, immediately and asynchronously: state=IDLE, fetch_pc=RESET_PC, count=0, head=tail=0, out_mem_ce=0, out_mem_pc=0, out_valid=0.
REQ-033 Reset mid-request: the in-flight response arriving after deassertion is not captured; the memory controller is reset by the same rst.
REQ-034 First request goes out in the first rdy-high cycle after rst deasserts.

Structure
REQ-035 TRUE/FALSE, ZERO_DATA, and DATA_WIDTH macros come from the shared constant header; no local redefinition.
REQ-036 FSM state encodings are defined in the shared constant header.
REQ-037 Sub-module fetch_queue (parametrised circular buffer: push, pop, flush, full, empty, head data); the FSM and fetch_pc remain in the top module.

Verification
REQ-038 Reset, memory responds 0x00000013 after 2 cycles, no stall -> requests at pc 0,4,8; out_pc 0 with out_instr 0x00000013 one cycle after first response.
REQ-039 in_issue_stall held high, QDEPTH=4 -> exactly 4 pushes, no fifth out_mem_ce; deassert stall -> one pop per cycle, next request after first pop.
REQ-040 Redirect to 0x100 while in WAIT -> queue empties, the following in_mem_ce is dropped, next request pc 0x100.
REQ-041 Redirect coincident with in_mem_ce and a pop -> no push, no issue, count=0, next request pc = redirect target.
REQ-042 rdy low for 5 cycles mid-WAIT with in_mem_ce pulsed -> no state change; resumes correctly when rdy is high.
REQ-043 rst asserted mid-WAIT between clock edges -> outputs clear immediately; first post-reset request pc = RESET_PC.
